// File: rtl/instr_encoder_pkg.sv
// Shared MIPS-I encoding constants: symbolic op codes, primary opcodes and
// R-type funct values. The control decoder imports the same package.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDU = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBU = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_SLT  = 4'd6,
    OP_JR   = 4'd7,
    OP_ADDI = 4'd8,
    OP_ORI  = 4'd9,
    OP_LUI  = 4'd10,
    OP_LW   = 4'd11,
    OP_SW   = 4'd12,
    OP_BEQ  = 4'd13,
    OP_J    = 4'd14,
    OP_JAL  = 4'd15
  } op_e;

  typedef enum logic {ST_RUN = 1'b0, ST_ERR = 1'b1} state_e;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_ADDI    = 6'b001000;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_SW      = 6'b101011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // funct field for the register-register ALU ops; 0 for anything else
  function automatic logic [5:0] funct_of(op_e op);
    case (op)
      OP_ADD:  return FN_ADD;
      OP_ADDU: return FN_ADDU;
      OP_SUB:  return FN_SUB;
      OP_SUBU: return FN_SUBU;
      OP_AND:  return FN_AND;
      OP_OR:   return FN_OR;
      OP_SLT:  return FN_SLT;
      default: return 6'b000000;
    endcase
  endfunction

  // primary opcode for I-type and J-type ops; SPECIAL for the rest
  function automatic logic [5:0] opcode_of(op_e op);
    case (op)
      OP_ADDI: return OPC_ADDI;
      OP_ORI:  return OPC_ORI;
      OP_LUI:  return OPC_LUI;
      OP_LW:   return OPC_LW;
      OP_SW:   return OPC_SW;
      OP_BEQ:  return OPC_BEQ;
      OP_J:    return OPC_J;
      OP_JAL:  return OPC_JAL;
      default: return OPC_SPECIAL;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// enc_fifo: synchronous FIFO with an extra pointer bit to tell full from
// empty, plus a synchronous flush. Head data is read combinationally.
module enc_fifo #(
  parameter int W     = 42,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata = mem[rd_q[AW-1:0]];

  // next pointers; flush wins over any same-cycle push/pop
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push && !full)  wr_d = wr_q + 1'b1;
      if (pop  && !empty) rd_d = rd_q + 1'b1;
    end
  end

  // pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS-I descriptors into 32-bit words tagged
// with consecutive word addresses, buffered in enc_fifo. An illegal
// descriptor parks the block in ERR until clear or reset.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [15:0]       count
);

  localparam int                FW   = 32 + ADDR_W;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  op_e               op;
  logic [31:0]       word;
  logic              legal;
  logic              accept, push, pop;
  logic              fifo_full, fifo_empty;
  logic [FW-1:0]     head;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic [FW-1:0]     hold_q, hold_d;

  assign op = op_e'(in_op);

  // encode the descriptor and flag immediates that do not fit the format
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_SLT: begin
        word  = {OPC_SPECIAL, in_rs, in_rt, in_rd, 5'b0, funct_of(op)};
        legal = (in_imm == '0);
      end
      OP_JR: begin
        word  = {OPC_SPECIAL, in_rs, 15'b0, FN_JR};
        legal = (in_imm == '0);
      end
      OP_LUI: begin
        word  = {OPC_LUI, 5'b0, in_rt, in_imm[15:0]};
        legal = (in_imm[25:16] == '0);
      end
      OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ: begin
        word  = {opcode_of(op), in_rs, in_rt, in_imm[15:0]};
        legal = (in_imm[25:16] == '0);
      end
      OP_J, OP_JAL: begin
        word  = {opcode_of(op), in_imm};
      end
      default: begin
        word  = '0;
        legal = 1'b1;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // FSM next state: clear always restarts, an illegal accept parks in ERR
  always_comb begin
    state_d = state_q;
    if (clear)                              state_d = ST_RUN;
    else if (state_q == ST_RUN && accept && !legal) state_d = ST_ERR;
  end

  // FSM outputs; ready is gated by reset_n so it reads 0 in the reset cycle
  always_comb begin
    in_ready = reset_n && (state_q == ST_RUN) && !fifo_full;
    err      = (state_q == ST_ERR);
  end

  assign accept = in_valid && in_ready;
  assign push   = accept && legal && !clear;
  assign pop    = out_valid && out_ready && !clear;

  enc_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .flush (clear),
    .push  (push),
    .wdata ({word, addr_q}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // address, pop counter and last-popped word next state
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    hold_d  = hold_q;
    if (clear) begin
      addr_d  = BASE;
      count_d = '0;
    end else begin
      if (push) addr_d = addr_q + ADDR_W'(1);
      if (pop) begin
        hold_d = head;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end
    end
  end

  // counter and hold registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q  <= BASE;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  // an empty FIFO keeps presenting the last word taken
  assign out_valid = !fifo_empty;
  assign out_instr = fifo_empty ? hold_q[FW-1:ADDR_W] : head[FW-1:ADDR_W];
  assign out_addr  = fifo_empty ? hold_q[ADDR_W-1:0]  : head[ADDR_W-1:0];
  assign count     = count_q;

endmodule
